// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and widths for the FIFO read-side stream.
// Occupancy enum, beat counter width and stats counter width.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int BEAT_W = 16;
  localparam int STAT_W = 32;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid2.sv
// fifo_rd_skid2: 2-entry data+last buffer with push/pop.
// Entry 0 is the head; entry 1 only fills while the head is stalled.
module fifo_rd_skid2
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [DSIZE-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic             head_valid_o,
  output logic [DSIZE-1:0] head_data_o,
  output logic             head_last_o,
  output occ_e             occ_o
);

  occ_e             occ_q, occ_d;
  logic [DSIZE-1:0] d0_q, d0_d;
  logic [DSIZE-1:0] d1_q, d1_d;
  logic             l0_q, l0_d;
  logic             l1_q, l1_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q <= OCC_EMPTY;
      d0_q  <= '0;
      d1_q  <= '0;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
    end else begin
      occ_q <= occ_d;
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      l0_q  <= l0_d;
      l1_q  <= l1_d;
    end
  end

  always_comb begin
    occ_d = occ_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    l0_d  = l0_q;
    l1_d  = l1_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push_i) begin
          d0_d  = push_data_i;
          l0_d  = push_last_i;
          occ_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push_i && pop_i) begin
          d0_d = push_data_i;
          l0_d = push_last_i;
        end else if (push_i) begin
          d1_d  = push_data_i;
          l1_d  = push_last_i;
          occ_d = OCC_TWO;
        end else if (pop_i) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // Push is gated off upstream while full.
        if (pop_i) begin
          d0_d  = d1_q;
          l0_d  = l1_q;
          occ_d = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  assign head_valid_o = (occ_q != OCC_EMPTY);
  assign head_data_o  = d0_q;
  assign head_last_o  = l0_q;
  assign occ_o        = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: rclk-domain FIFO drain into a framed valid/ready stream.
// Define FIFO_RD_STREAM_STATS_EN to add stat_words/stat_stall outputs.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rd_en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  occ_e              occ;
  logic              fire;
  logic              tag_last;
  logic [BEAT_W-1:0] beat_q, beat_d;

  // Pop gating sees only registered occupancy, never out_ready.
  assign rinc     = rd_en & ~rempty & (occ != OCC_TWO) & ~rrst;
  assign fire     = out_valid & out_ready;
  assign tag_last = (beat_q == LAST_BEAT);
  assign busy     = (occ != OCC_EMPTY);

  always_comb begin
    beat_d = beat_q;
    if (rinc) begin
      beat_d = tag_last ? '0 : beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  fifo_rd_skid2 #(
    .DSIZE(DSIZE)
  ) u_skid (
    .clk_i       (rclk),
    .rst_i       (rrst),
    .push_i      (rinc),
    .push_data_i (rdata),
    .push_last_i (tag_last),
    .pop_i       (fire),
    .head_valid_o(out_valid),
    .head_data_o (out_data),
    .head_last_o (out_last),
    .occ_o       (occ)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STAT_W-1:0] words_q, words_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  always_comb begin
    words_d = words_q;
    stall_d = stall_q;
    if (rinc) begin
      words_d = words_q + STAT_W'(1);
    end
    if (out_valid & ~out_ready) begin
      stall_d = sat_inc(stall_q);
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench with a queue-level stream model.
// Two instances (BURST_LEN 16 and 4) share one FIFO model and stimulus.
module tb_fifo_rd_stream;

  typedef struct packed {
    logic [7:0] d;
    logic       l16;
    logic       l4;
  } ent_t;

  logic       rclk;
  logic       rrst;
  logic       rd_en;
  logic       rempty;
  logic [7:0] rdata;
  logic       out_ready;

  logic       rinc16, ov16, ol16, busy16;
  logic [7:0] od16;
  logic       rinc4, ov4, ol4, busy4;
  logic [7:0] od4;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] sw16, ss16, sw4, ss4;
  logic [31:0] m_sw, m_ss;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   pops  = 0;
  int   pop_cnt;
  int   first_pop;
  int   last_pop;
  logic rinc_s = 1'b0;

  logic [7:0] fifo[$];
  ent_t       m[$];
  ent_t       dlv[$];

  fifo_rd_stream #(.DSIZE(8), .BURST_LEN(16)) u16 (
    .rclk(rclk), .rrst(rrst), .rd_en(rd_en), .rempty(rempty),
    .rdata(rdata), .rinc(rinc16), .out_valid(ov16), .out_data(od16),
    .out_last(ol16), .out_ready(out_ready), .busy(busy16)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .stat_words(sw16), .stat_stall(ss16)
`endif
  );

  fifo_rd_stream #(.DSIZE(8), .BURST_LEN(4)) u4 (
    .rclk(rclk), .rrst(rrst), .rd_en(rd_en), .rempty(rempty),
    .rdata(rdata), .rinc(rinc4), .out_valid(ov4), .out_data(od4),
    .out_last(ol4), .out_ready(out_ready), .busy(busy4)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .stat_words(sw4), .stat_stall(ss4)
`endif
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic refresh();
    rempty = (fifo.size() == 0);
    rdata  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
    refresh();
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fifo.push_back(base + 8'(i));
    refresh();
  endtask

  task automatic clear_logs();
    dlv.delete();
    pop_cnt   = 0;
    first_pop = -1;
    last_pop  = -1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    tick();
    tick();
    rrst = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((fifo.size() != 0 || m.size() != 0) && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n >= max), 32'd0);
  endtask

  // Reference model: pop when allowed, tag by pop count since reset.
  always @(posedge rclk) begin
    logic er, ev;
    cyc++;
    er = rd_en && fifo.size() != 0 && m.size() < 2 && !rrst;
    ev = m.size() != 0;
    if (rrst) begin
      m.delete();
      pops = 0;
`ifdef FIFO_RD_STREAM_STATS_EN
      m_sw = 0;
      m_ss = 0;
`endif
    end else begin
`ifdef FIFO_RD_STREAM_STATS_EN
      if (ev && !out_ready && m_ss != 32'hFFFF_FFFF) m_ss = m_ss + 1;
      if (er) m_sw = m_sw + 1;
`endif
      if (ev && out_ready) void'(m.pop_front());
      if (er) begin
        m.push_back('{fifo[0], (pops % 16) == 15, (pops % 4) == 3});
        pops++;
      end
    end
    if (rinc_s && fifo.size() != 0) void'(fifo.pop_front());
  end

  always @(negedge rclk) begin
    logic er, ev;
    er = rd_en && fifo.size() != 0 && m.size() < 2 && !rrst;
    ev = !rrst && m.size() != 0;
    chk("rinc16", rinc16, er);
    chk("rinc4", rinc4, er);
    chk("valid16", ov16, ev);
    chk("valid4", ov4, ev);
    chk("busy16", busy16, ev);
    chk("busy4", busy4, ev);
    if (ev) begin
      chk("data16", od16, m[0].d);
      chk("last16", ol16, m[0].l16);
      chk("data4", od4, m[0].d);
      chk("last4", ol4, m[0].l4);
    end
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("stat_words16", sw16, m_sw);
    chk("stat_stall16", ss16, m_ss);
    chk("stat_words4", sw4, m_sw);
    chk("stat_stall4", ss4, m_ss);
`endif
    rinc_s = rinc16;
    if (rinc16) begin
      pop_cnt++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (ov16 && out_ready) dlv.push_back('{od16, ol16, ol4});
  end

  initial begin
    rrst      = 1'b1;
    rd_en     = 1'b0;
    out_ready = 1'b0;
    rempty    = 1'b1;
    rdata     = 8'h00;
    clear_logs();
`ifdef FIFO_RD_STREAM_STATS_EN
    m_sw = 0;
    m_ss = 0;
`endif
    tick();
    tick();
    chk("rst_valid", ov16, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_data", od16, 0);
    chk("rst_last", ol16, 0);
    chk("rst_rinc", rinc16, 0);
    rrst = 1'b0;

    // Full-rate burst of 16 words.
    preload(8'h01, 16);
    clear_logs();
    rd_en     = 1'b1;
    out_ready = 1'b1;
    drain(100);
    chk("a_count", dlv.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("a_data", dlv[i].d, 32'(i + 1));
      chk("a_last16", dlv[i].l16, 32'(i == 15));
    end
    chk("a_pops", pop_cnt, 16);
    chk("a_pop_span", last_pop - first_pop, 15);

    // Ten-cycle stall right at the start.
    rd_en = 1'b0;
    do_reset();
    preload(8'h01, 16);
    clear_logs();
    out_ready = 1'b0;
    rd_en     = 1'b1;
    repeat (10) tick();
    chk("b_stall_pops", pop_cnt, 2);
    chk("b_hold_data", od16, 8'h01);
    chk("b_hold_valid", ov16, 1);
    chk("b_stall_rinc", rinc16, 0);
    out_ready = 1'b1;
    drain(100);
    chk("b_count", dlv.size(), 16);
    for (int i = 0; i < 16; i++) chk("b_data", dlv[i].d, 32'(i + 1));

    // Short bursts: 10 words then 2 more.
    rd_en = 1'b0;
    do_reset();
    preload(8'h01, 10);
    clear_logs();
    rd_en = 1'b1;
    drain(100);
    chk("c_count10", dlv.size(), 10);
    for (int i = 0; i < 10; i++) begin
      chk("c_last4", dlv[i].l4, 32'(i == 3 || i == 7));
      chk("c_last16", dlv[i].l16, 0);
    end
    repeat (3) tick();
    preload(8'h0B, 2);
    drain(100);
    chk("c_count12", dlv.size(), 12);
    chk("c_last4_w11", dlv[10].l4, 0);
    chk("c_last4_w12", dlv[11].l4, 1);

    // Drop rd_en after three pops.
    rd_en = 1'b0;
    do_reset();
    preload(8'h01, 16);
    clear_logs();
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    repeat (4) tick();
    chk("d_pops", pop_cnt, 3);
    chk("d_count", dlv.size(), 3);
    chk("d_word3", dlv[2].d, 8'h03);
    chk("d_busy", busy16, 0);
    chk("d_rinc", rinc16, 0);

    // Reset while the buffer is full.
    out_ready = 1'b0;
    rd_en     = 1'b1;
    repeat (4) tick();
    chk("e_pops", pop_cnt, 5);
    chk("e_busy", busy16, 1);
    rrst = 1'b1;
    #1;
    chk("e_rst_valid", ov16, 0);
    chk("e_rst_last", ol16, 0);
    chk("e_rst_rinc", rinc16, 0);
    chk("e_rst_busy4", busy4, 0);
    tick();
    tick();
    rrst = 1'b0;
    preload(8'h21, 5);
    clear_logs();
    out_ready = 1'b1;
    drain(100);
    chk("e_count", dlv.size(), 16);
    chk("e_first", dlv[0].d, 8'h06);
    chk("e_w11", dlv[10].d, 8'h10);
    chk("e_w12", dlv[11].d, 8'h21);
    for (int i = 0; i < 16; i++) begin
      chk("e_last16", dlv[i].l16, 32'(i == 15));
      chk("e_last4", dlv[i].l4, 32'((i % 4) == 3));
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    // Five stall cycles then sixteen words.
    begin
      int n;
      rd_en = 1'b0;
      do_reset();
      preload(8'h01, 16);
      clear_logs();
      out_ready = 1'b0;
      rd_en     = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (!ov16 && n < 10);
      chk("f_valid_wait", ov16, 1);
      repeat (5) tick();
      out_ready = 1'b1;
      drain(100);
      chk("f_stat_stall", ss16, 5);
      chk("f_stat_words", sw16, 16);
    end
`endif

    rd_en = 1'b0;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain controller for the dual-clock FIFO, living entirely in the `rclk` domain. It pops words through the FIFO read port (`rempty`, `rinc`, `rdata`) and presents them downstream as a valid/ready stream with burst framing. A 2-entry output buffer sustains one word per cycle without any combinational path from `out_ready` to `rinc`.

## Interface

Parameters:
- `DSIZE`, default 8: data width; must match FIFO `DSIZE`.
- `BURST_LEN`, default 16: words per burst; `out_last` marks the final word. Legal range 1..65535.

Ports:
- `rclk`, input, 1: read-domain clock; all logic is on its rising edge.
- `rrst`, input, 1: reset, asynchronous, active-high.
- `rd_en`, input, 1: drain enable; when low, no new pops.
- `rempty`, input, 1: FIFO empty flag (registered in the FIFO).
- `rdata`, input, DSIZE: FIFO head word; valid whenever `rempty`=0.
- `rinc`, output, 1: FIFO pop strobe.
- `out_valid`, output, 1: stream word valid.
- `out_data`, output, DSIZE: stream word.
- `out_last`, output, 1: last word of the current burst.
- `out_ready`, input, 1: downstream accept.
- `busy`, output, 1: buffer non-empty.

## Operation

- Buffer occupancy `occ` is 0, 1 or 2, with states EMPTY, ONE and TWO.
- `rinc = rd_en & ~rempty & (occ != 2) & ~rrst`. It depends only on registered state and `rd_en`, never on `out_ready`.
- On a pop edge, `rdata` is captured into the buffer tail together with its `last` tag.
- Output fire is `out_valid & out_ready`. The head is removed and the second entry shifts to the head.
- State transitions:
  - EMPTY goes to ONE on pop.
  - ONE goes to TWO on pop without fire.
  - ONE stays in ONE on pop with fire.
  - ONE goes to EMPTY on fire without pop.
  - TWO goes to ONE on fire. No pop is possible in TWO.
- Beat counter `beat`, 16 bits, counts popped words.
  - The tag is `last = (beat == BURST_LEN-1)`.
  - `beat` wraps to 0 after the last word. Otherwise it increments by 1 on each pop.
  - Framing is decided at pop time, not at output time.
- `out_data` and `out_last` hold stable while `out_valid & ~out_ready`. `out_valid` never drops without a fire.
- `busy = (occ != 0)`.
- Deasserting `rd_en` stops pops only. Buffered words still drain, and `beat` is retained.
- Reset:
  - `rrst` asserted at any time clears `occ`, `beat`, `out_valid`, `out_data` and `out_last` to 0, and forces `rinc` to 0 immediately (combinational).
  - A partially delivered burst is discarded.
  - After `rrst` deasserts, the first pop carries beat 0.

## Timing

- Pop-to-output latency is 1 cycle. A word popped at edge k shows `out_valid`=1 after edge k.
- With `out_ready` held at 1 and the FIFO non-empty, throughput is 1 word per cycle in steady state ONE.
- Backpressure: with `out_ready`=0, at most 2 pops occur after the stall begins, then `rinc` stays low.
- Recovery: the cycle after `out_ready` returns, `occ` drops to 1 and `rinc` may reassert.
- `rempty` updates on the same edge as the pop, so back-to-back pops need no idle cycle.

## Configuration

- `FIFO_RD_STREAM_STATS_EN` defined adds two outputs:
  - `stat_words` (32 bits): wrapping count of popped words.
  - `stat_stall` (32 bits): saturating count of cycles with `out_valid & ~out_ready`.
  - Both reset to 0 on `rrst`.
- Macro undefined: neither port nor counter exists. Functional behaviour is otherwise identical.

## Structure

- Package `fifo_rd_pkg` holds:
  - the occupancy state enum (EMPTY, ONE, TWO);
  - localparam `BEAT_W` = 16;
  - the stats counter width localparam.
- Sub-module `fifo_rd_skid2` is the 2-entry data+last buffer with push/pop and `occ`. The top level holds pop gating, the beat counter and the stats.

## Test plan

- FIFO preloaded with 0x01..0x10, `BURST_LEN`=16, `out_ready`=1, `rd_en`=1 -> 16 consecutive output beats 0x01..0x10, `out_last` only on 0x10, `rinc` high for 16 consecutive cycles.
- Same preload, `out_ready`=0 for 10 cycles, then 1 -> exactly 2 pops during the stall, `out_data` held at 0x01, then in-order delivery of all 16 words with none lost or duplicated.
- `BURST_LEN`=4 with 10 words -> `out_last` on words 4 and 8, none on 10. Then 2 more words -> `out_last` on word 12.
- `rd_en` dropped after 3 pops with `out_ready`=1 -> 3 words delivered, `busy` falls to 0, `rinc` stays 0 although `rempty`=0.
- `rrst` pulsed mid-burst with `occ`=2 -> `out_valid`, `out_last` and `rinc` are 0 during reset. The next pop is tagged beat 0, and `out_last` appears `BURST_LEN` words later.
- With `FIFO_RD_STREAM_STATS_EN`, a 5-cycle stall followed by 16 words -> `stat_stall`=5 and `stat_words`=16.
